// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divisor helper.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering bytes ahead of the UART serialiser.
// DEPTH must be a power of two; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic                      wr_en;
    logic                      rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // NOTE: the storage array has no reset; the pointers alone define validity, so the
    // array maps onto plain RAM/flops without a reset network.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// Byte UART transmitter: FIFO-buffered valid/ready input, 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      tx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      bit_end;
    logic                      load;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;

`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign fifo_push = tx_valid && tx_ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (fifo_push),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    // NOTE: every output of this block is given a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        load     = 1'b0;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                load  = !fifo_empty;
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Next bit is already waiting in shift_q[1] before the shift lands.
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (fifo_empty) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Shared frame launch from IDLE or straight out of STOP, giving back-to-back frames.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            cnt_d    = '0;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, a line decoder rebuilds frames.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_tx;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int C        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         acc_q[$];
    int         cyc = 0;
    int         frames = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference line model: a frame is start(0), 8 data bits LSB first, [even parity], stop(1).
    task automatic compare_frame(input logic [NB-1:0] bits);
        logic [7:0] rx;
        logic [7:0] want;
        rx = bits[8:1];
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("start_bit", 32'(bits[0]), 32'd0);
            check("frame_data", 32'(rx), 32'(want));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(bits[9]), 32'(^want));
`endif
            check("stop_bit", 32'(bits[NB-1]), 32'd1);
        end
    endtask

    initial begin : monitor
        int k;
        bit in_frame;
        logic [NB-1:0] bits;
        k = 0;
        in_frame = 1'b0;
        bits = '0;
        forever begin
            @(negedge CLK);
            if (!reset) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    k = 0;
                    starts.push_back(cyc);
                end
            end else begin
                k++;
            end
            if (in_frame && (k % C) == C / 2) begin
                bits[k / C] = tx;
                if (k / C == NB - 1) begin
                    in_frame = 1'b0;
                    frames++;
                    compare_frame(bits);
                end
            end
        end
    end

    task automatic send_stream(input logic [7:0] data[$]);
        int n;
        acc_q.delete();
        @(posedge CLK);
        #1;
        tx_valid = 1'b1;
        foreach (data[i]) begin
            tx_data = data[i];
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!tx_ready && n < 2000);
            check("push_ready", 32'(tx_ready), 32'd1);
            if (!tx_ready) begin
                tx_valid = 1'b0;
                return;
            end
            acc_q.push_back(cyc + 1);
            exp_q.push_back(data[i]);
            @(posedge CLK);
            #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int base);
        int n;
        n = 0;
        while (starts.size() <= base && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("start_seen", 32'(starts.size() > base), 32'd1);
    endtask

    task automatic wait_idle(output int when);
        int n;
        n = 0;
        while (tx_busy && n < 20 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        check("idle_reached", 32'(tx_busy), 32'd0);
        when = cyc;
    endtask

    initial begin : stimulus
        logic [7:0] q[$];
        int base;
        int t_idle;
        int low_cnt;
        int fr0;

        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #3;
        check("reset_tx", 32'(tx), 32'd1);
        reset = 1'b1;

        // Idle after reset: line high, ready, not busy.
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            check("idle_outputs", 32'({tx, tx_ready, tx_busy}), 32'b110);
        end

        // Single byte: start one cycle after acceptance, busy for exactly one frame.
        base = starts.size();
        q = {8'hA5};
        send_stream(q);
        wait_start(base);
        check("a5_start_latency", 32'(starts[base]), 32'(acc_q[0] + 1));
        wait_idle(t_idle);
        check("a5_busy_fall", 32'(t_idle), 32'(starts[base] + FRAME));
        repeat (20) @(posedge CLK);

        // Held tx_valid: four bytes fill the FIFO behind the one in flight.
        base = starts.size();
        q = {8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h7E};
        send_stream(q);
        for (int i = 1; i < 5; i++) begin
            check("b2b_accept", 32'(acc_q[i]), 32'(acc_q[0] + i));
        end
        // Ready returns the cycle after the first frame's stop pops the FIFO.
        check("sixth_accept", 32'(acc_q[5]), 32'(starts[base] + FRAME + 1));
        wait_idle(t_idle);
        check("six_frames", 32'(starts.size() - base), 32'd6);
        for (int i = 0; i < 5; i++) begin
            if (starts.size() > base + i + 1) begin
                check("frame_gap", 32'(starts[base + i + 1] - starts[base + i]), 32'(FRAME));
            end
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge CLK);

        // Reset during data bit 3 of 0x0F with two bytes still queued.
        base = starts.size();
        q = {8'h0F, 8'h11, 8'h22};
        send_stream(q);
        wait_start(base);
        while (cyc < starts[base] + C * 4 + 6) @(negedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        exp_q.delete();
        fr0 = frames;
        repeat (3) @(posedge CLK);
        #3;
        reset = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (tx !== 1'b1) low_cnt++;
        end
        check("no_restart", 32'(low_cnt), 32'd0);
        check("no_frames_after_abort", 32'(frames - fr0), 32'd0);
        check("abort_idle", 32'(tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight, 0x03 even.
        base = starts.size();
        q = {8'h07, 8'h03};
        send_stream(q);
        wait_idle(t_idle);
        check("parity_frames", 32'(starts.size() - base), 32'd2);
        if (starts.size() >= base + 2) begin
            check("parity_frame_len", 32'(starts[base + 1] - starts[base]), 32'd176);
            check("parity_busy_fall", 32'(t_idle - starts[base + 1]), 32'd176);
        end
        repeat (20) @(posedge CLK);
`endif

        // Full FIFO: a tx_valid pulse carrying 0xEE must be dropped.
        base = starts.size();
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 255)));
        send_stream(q);
        @(negedge CLK);
        check("full_not_ready", 32'(tx_ready), 32'd0);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        @(posedge CLK);
        #1;
        tx_valid = 1'b0;
        wait_idle(t_idle);
        check("full_frames", 32'(starts.size() - base), 32'd5);
        check("full_drained", 32'(exp_q.size()), 32'd0);
        repeat (10) @(posedge CLK);

        // Random bytes with random gaps, some landing mid-frame.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3) * $urandom_range(0, 60)) @(posedge CLK);
            q.delete();
            q.push_back(8'($urandom_range(0, 255)));
            send_stream(q);
        end
        wait_idle(t_idle);
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("final_tx_high", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
